// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that steps the shared execute-stage ALU.
// Define ALU_MUL_EARLY_EXIT_EN to stop once the remaining multiplier is zero.
module alu_mul_seq #(
   parameter int MAX_ITER = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] mul_a,
   input  logic [31:0] mul_b,
   output logic        ready,
   output logic        done,
   output logic [31:0] product,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_c,
   input  logic [31:0] alu_out,
   input  logic        alu_z
);

   typedef enum logic [2:0] {
      IDLE, TEST, ADD, SHL, SHR, DONE
   } state_t;

   state_t      st, st_nx;
   logic [31:0] mcand, mplr, acc, prod_q;
   logic [5:0]  iter, iter_inc;
   logic        ee, accept;

   assign iter_inc = iter + 6'd1;
   assign accept   = (st == IDLE) && start && !flush;

`ifdef ALU_MUL_EARLY_EXIT_EN
   assign ee = alu_z;
`else
   assign ee = 1'b0;
`endif

   // A flush in DONE suppresses both the pulse and the result update.
   assign ready   = (st == IDLE);
   assign done    = (st == DONE) && !flush;
   assign product = done ? acc : prod_q;

   always_comb begin
      st_nx = st;
      alu_a = 32'd0;
      alu_b = 32'd0;
      alu_c = 4'd0;
      unique case (st)
         IDLE: if (accept) st_nx = TEST;
         TEST: begin
            alu_a = mplr;
            alu_b = 32'd1;
            alu_c = 4'd0;
            st_nx = alu_z ? SHL : ADD;
         end
         ADD: begin
            alu_a = acc;
            alu_b = mcand;
            alu_c = 4'd2;
            st_nx = SHL;
         end
         SHL: begin
            alu_a = mcand;
            alu_b = 32'd1;
            alu_c = 4'd3;
            st_nx = SHR;
         end
         SHR: begin
            alu_a = mplr;
            alu_b = 32'd1;
            alu_c = 4'd4;
            if (iter_inc == 6'(MAX_ITER) || ee)
               st_nx = DONE;
            else
               st_nx = TEST;
         end
         DONE:    st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
      if (flush) st_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= 32'd0;
         mplr   <= 32'd0;
         acc    <= 32'd0;
         iter   <= 6'd0;
         prod_q <= 32'd0;
      end else if (accept) begin
         mcand <= mul_a;
         mplr  <= mul_b;
         acc   <= 32'd0;
         iter  <= 6'd0;
      end else if (!flush) begin
         unique case (st)
            ADD: acc <= alu_out;
            SHL: mcand <= alu_out;
            SHR: begin
               mplr <= alu_out;
               iter <= iter_inc;
            end
            DONE: prod_q <= acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: ALU model, directed cases and random products.
// Latency/opcode model follows ALU_MUL_EARLY_EXIT_EN when defined.
module tb_alu_mul_seq;

   localparam int MAXI = 32;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [31:0] mul_a, mul_b;
   logic        ready, done;
   logic [31:0] product, alu_a, alu_b, alu_out;
   logic [3:0]  alu_c;
   logic        alu_z;

   int n_chk = 0;
   int n_fail = 0;

   alu_mul_seq #(.MAX_ITER(MAXI)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
      .mul_a(mul_a), .mul_b(mul_b), .ready(ready), .done(done),
      .product(product), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_out(alu_out), .alu_z(alu_z)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_out = 32'd0;
      case (alu_c)
         4'd0: alu_out = alu_a & alu_b;
         4'd1: alu_out = alu_a | alu_b;
         4'd2: alu_out = alu_a + alu_b;
         4'd3: alu_out = alu_a << alu_b[4:0];
         4'd4: alu_out = alu_a >> alu_b[4:0];
         4'd6: alu_out = alu_a - alu_b;
         4'd7: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'd12: alu_out = ~(alu_a | alu_b);
         default: alu_out = 32'd0;
      endcase
   end
   assign alu_z = (alu_out == 32'd0);

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int n_iter(input logic [31:0] b);
      int n;
`ifdef ALU_MUL_EARLY_EXIT_EN
      n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      if (n > MAXI) n = MAXI;
`else
      n = MAXI;
`endif
      return n;
   endfunction

   function automatic int lat_of(input logic [31:0] b);
      int t;
      t = 1;
      for (int i = 0; i < n_iter(b); i++) t += 3 + int'(b[i]);
      return t;
   endfunction

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
      int cyc;
      int bad;
      logic [3:0] ops[$];
      logic [3:0] eops[$];
      logic [31:0] expp;
      expp = a * b;
      @(negedge clk);
      check("ready_pre", 32'(ready), 32'd1);
      start = 1'b1; mul_a = a; mul_b = b;
      @(negedge clk);
      start = 1'b0; mul_a = $urandom; mul_b = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc < 400) begin
         ops.push_back(alu_c);
         @(negedge clk);
         cyc++;
      end
      ops.push_back(alu_c);
      check("latency", 32'(cyc), 32'(lat_of(b)));
      check("product", product, expp);
      check("ready_in_done", 32'(ready), 32'd0);
      for (int i = 0; i < n_iter(b); i++) begin
         eops.push_back(4'd0);
         if (b[i]) eops.push_back(4'd2);
         eops.push_back(4'd3);
         eops.push_back(4'd4);
      end
      eops.push_back(4'd0);
      bad = (ops.size() != eops.size()) ? 1 : 0;
      if (bad == 0)
         foreach (ops[i]) if (ops[i] !== eops[i]) bad++;
      check("opseq", 32'(bad), 32'd0);
      @(negedge clk);
      check("ready_after", 32'(ready), 32'd1);
      check("done_after", 32'(done), 32'd0);
      check("product_held", product, expp);
   endtask

   initial begin
      logic [31:0] prev, ra, rb;
      int lat, cyc;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      mul_a = 32'd0; mul_b = 32'd0;
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_product", product, 32'd0);
      check("rst_alu_c", 32'(alu_c), 32'd0);
      check("rst_alu_ab", alu_a | alu_b, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_alu_c", 32'(alu_c), 32'd0);
         check("idle_alu_ab", alu_a | alu_b, 32'd0);
      end

      run_mul(32'd5, 32'd3);
      run_mul(32'hFFFF_FFFF, 32'd0);
      run_mul(32'h0001_0000, 32'h0001_0000);

      // flush mid-run
      prev = product;
      @(negedge clk);
      start = 1'b1; mul_a = 32'd7; mul_b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1 check("flush_t3_done", 32'(done), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", 32'(ready), 32'd1);
      check("flush_done", 32'(done), 32'd0);
      check("flush_product", product, prev);
      run_mul(32'd7, 32'd6);

      // flush with start in IDLE
      @(negedge clk);
      start = 1'b1; flush = 1'b1; mul_a = 32'd9; mul_b = 32'd9;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_ign", 32'(ready), 32'd1);

      // flush during DONE
      prev = product;
      lat = lat_of(32'd5);
      start = 1'b1; mul_a = 32'd3; mul_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < lat; k++) @(negedge clk);
      check("pre_flush_done", 32'(done), 32'd1);
      flush = 1'b1;
      #1;
      check("flushdone_done", 32'(done), 32'd0);
      check("flushdone_prod", product, prev);
      @(negedge clk);
      flush = 1'b0;
      check("flushdone_idle", 32'(ready), 32'd1);
      check("flushdone_prod2", product, prev);

      // start held high
      start = 1'b1; mul_a = 32'd2; mul_b = 32'd2;
      @(negedge clk);
      cyc = 1;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("held_latency", 32'(cyc), 32'(lat_of(32'd2)));
      check("held_product", product, 32'd4);
      @(negedge clk);
      check("held_ready_up", 32'(ready), 32'd1);
      @(negedge clk);
      check("held_reaccept", 32'(ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_product", product, 32'd0);
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_alu_c", 32'(alu_c), 32'd0);
      @(negedge clk);
      check("midrst_done2", 32'(done), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;

      for (int r = 0; r < 6; r++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_mul(ra, rb);
      end
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiply sequencer that time-steps the shared 32-bit ALU (and/or/add/sll/srl/sub/slt/nor) through a shift-and-add loop. It sits beside the ALU in the execute stage and owns the ALU's `a`/`b`/`c` inputs while busy. It returns the low 32 bits of `mul_a * mul_b`, using only existing ALU operations. No dedicated multiplier is instantiated.

## Interface
- `MAX_ITER`, 32: maximum shift-add iterations, 1..32. Multiplier bits at index ≥ MAX_ITER are ignored.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; accepted only when `ready`=1
- `flush`  in  1  synchronous abort; returns to IDLE, no `done`
- `mul_a`  in  32  multiplicand, sampled on accept
- `mul_b`  in  32  multiplier, sampled on accept
- `ready`  out  1  high in IDLE only
- `done`  out  1  one-cycle pulse, `product` valid
- `product`  out  32  result register, held until next accept
- `alu_a`  out  32  ALU operand a
- `alu_b`  out  32  ALU operand b
- `alu_c`  out  4  ALU opcode (0 and, 2 add, 3 sll, 4 srl)
- `alu_out`  in  32  ALU result (combinational, same cycle)
- `alu_z`  in  1  ALU zero flag for `alu_out`

## Operation
- Registers: `mcand`, `mplr`, `acc` (32 each), `iter` (6 bits), state.
- Reset values: state IDLE, all registers 0. Outputs: `ready`=1, `done`=0, `product`=0, `alu_a`=`alu_b`=0, `alu_c`=0.
- `alu_a`/`alu_b`/`alu_c` are decoded combinationally from state. In IDLE and DONE they drive 0/0/0.
- IDLE: on `start`, load `mcand`←`mul_a`, `mplr`←`mul_b`, `acc`←0, `iter`←0, then go to TEST.
- TEST: drive a=`mplr`, b=1, c=0.
  - If `alu_z`=0, go to ADD.
  - Otherwise, go to SHL.
- ADD: drive a=`acc`, b=`mcand`, c=2. Set `acc`←`alu_out` (mod 2^32), then go to SHL.
- SHL: drive a=`mcand`, b=1, c=3. Set `mcand`←`alu_out`, then go to SHR.
- SHR: drive a=`mplr`, b=1, c=4. Set `mplr`←`alu_out` and `iter`←`iter`+1.
  - Go to DONE if `iter`+1 = MAX_ITER, or if early exit is enabled and `alu_z`=1.
  - Otherwise, go to TEST.
- DONE: set `done`=1 and `product`←`acc`, then go to IDLE.
- `start` is ignored while `ready`=0; no queueing.
- `flush` is honored in any non-IDLE state, including DONE, and has priority over all transitions:
  - next state is IDLE, with no `done` pulse;
  - `product` keeps its previous value.
- `flush` together with `start` in IDLE: `start` is ignored.
- Overflow wraps silently. Signed operands give the correct low 32 bits.

## Timing
- Accept cycle is T0. TEST is entered at T1.
- Each iteration takes 3 cycles, or 4 when the tested multiplier bit is 1.
- `done` is high at cycle T(1 + Σ iteration cycles). `product` is valid from that same cycle.
- `ready` rises the cycle after `done`. Back-to-back: `start` in that cycle is accepted.
- Iteration count:
  - Early exit enabled: N = max(1, index of highest set bit of `mul_b` + 1), capped at MAX_ITER.
  - Early exit disabled: N = MAX_ITER.
- `rst_n` low mid-operation forces all outputs to their reset values immediately, with no `done`.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN`:
  - Defined: SHR terminates when the shifted multiplier is zero (`alu_z`=1).
  - Undefined: always runs exactly MAX_ITER iterations, and `alu_z` is used only in TEST.
- The result is identical either way; only latency differs.

## Test plan
- Reset: hold `rst_n`=0 → `ready`=1, `done`=0, `product`=0, `alu_c`=0. Release; idle for 5 cycles → no ALU activity (opcode 0, operands 0).
- `mul_a`=5, `mul_b`=3, early exit on → `done` at T9, `product`=15. ALU opcode sequence: 0,2,3,4,0,2,3,4.
- `mul_b`=0, `mul_a`=0xFFFFFFFF → early exit on: `done` at T4, `product`=0. Early exit off: `done` at T97, `product`=0.
- `mul_a`=0x10000, `mul_b`=0x10000 (early exit off) → `product`=0 (wrap); `done` at T98.
- `mul_a`=7, `mul_b`=6: assert `flush` at T3 → IDLE at T4, no `done`, `product` unchanged. Then `start` with `mul_a`=7, `mul_b`=6 → `product`=42.
- `start` held high continuously with `mul_a`=2, `mul_b`=2 → exactly one accept per `done`; second accept occurs the cycle after `done`. Asserting `rst_n`=0 mid-run gives no `done` and `product`=0.
